mips_trace_checker: RTL and testbench

Synthesizable, parametrised self-checking trace comparator for the MIPS processor bring-up flow. It holds a preloaded table of expected per-cycle channel values (addr, writedata, pcout, wrData, Ain, Bin, packed control fields, ...). On each sample strobe it compares the live processor probes against the current vector, counts mismatches, and captures the first failure. It generalises the simulation-only vector check to N channels of arbitrary width, per-channel don't-care masks, an explicit end marker, and an optional stop-on-error mode, so the same check can run in simulation and on the FPGA.

---
 rtl/mips_trace_checker.sv | 147 ++++++++++++++
 tb/tb_mips_trace_checker.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_checker.sv
// rtl/mips_trace_checker.sv - preloaded-vector trace comparator with first-failure capture
module mips_trace_checker #(
    parameter int NUM_CH      = 6,
    parameter int CH_W        = 32,
    parameter int DEPTH       = 128,
    parameter int STOP_ON_ERR = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic [AW-1:0]          load_addr,
    input  logic [NUM_CH*CH_W-1:0] load_data,
    input  logic [NUM_CH-1:0]      load_mask,
    input  logic                   load_last,
    input  logic                   start,
    input  logic                   sample,
    input  logic [NUM_CH*CH_W-1:0] observed,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   err,
    output logic [15:0]            error_count,
    output logic [AW:0]            vector_num,
    output logic [AW-1:0]          first_err_vec,
    output logic [NUM_CH-1:0]      first_err_ch
);

    localparam int DW = NUM_CH * CH_W;
    localparam logic [AW:0]   VN_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [AW:0]         vector_num_q, vector_num_d;
    logic [15:0]         error_count_q, error_count_d;
    logic [AW-1:0]       first_err_vec_q, first_err_vec_d;
    logic [NUM_CH-1:0]   first_err_ch_q, first_err_ch_d;
    logic                err_q, err_d;

    // Vector table is deliberately outside the reset domain so it survives a reset.
    logic [DW-1:0]       tbl_data [DEPTH];
    logic [NUM_CH-1:0]   tbl_mask [DEPTH];
    logic [DEPTH-1:0]    tbl_last;

    logic [DW-1:0]       cur_data;
    logic [NUM_CH-1:0]   cur_mask;
    logic                cur_last;
    logic [NUM_CH-1:0]   mism;
    logic                any_mism;
    logic                ptr_at_end;

    always_ff @(posedge clk) begin
        if (load_en && (state_q == ST_IDLE)) begin
            tbl_data[load_addr] <= load_data;
            tbl_mask[load_addr] <= load_mask;
            tbl_last[load_addr] <= load_last;
        end
    end

    always_comb begin
        cur_data   = tbl_data[ptr_q];
        cur_mask   = tbl_mask[ptr_q];
        cur_last   = tbl_last[ptr_q];
        ptr_at_end = (ptr_q == {AW{1'b1}});
        mism       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            mism[k] = cur_mask[k] & (observed[k*CH_W +: CH_W] != cur_data[k*CH_W +: CH_W]);
        end
        any_mism = |mism;
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        vector_num_d    = vector_num_q;
        error_count_d   = error_count_q;
        first_err_vec_d = first_err_vec_q;
        first_err_ch_d  = first_err_ch_q;
        err_d           = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d         = ST_RUN;
                    ptr_d           = '0;
                    vector_num_d    = '0;
                    error_count_d   = '0;
                    first_err_vec_d = '0;
                    first_err_ch_d  = '0;
                end
            end
            ST_RUN: begin
                if (sample) begin
                    if (any_mism) begin
                        err_d = 1'b1;
                        if (error_count_q != 16'hFFFF) begin
                            error_count_d = error_count_q + 16'd1;
                        end
                        // A zero count means nothing has failed yet this run.
                        if (error_count_q == 16'd0) begin
                            first_err_vec_d = ptr_q;
                            first_err_ch_d  = mism;
                        end
                    end
                    vector_num_d = vector_num_q + VN_ONE;
                    ptr_d        = ptr_q + PTR_ONE;
                    if (cur_last || ptr_at_end || ((STOP_ON_ERR != 0) && any_mism)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            ptr_q           <= '0;
            vector_num_q    <= '0;
            error_count_q   <= '0;
            first_err_vec_q <= '0;
            first_err_ch_q  <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            vector_num_q    <= vector_num_d;
            error_count_q   <= error_count_d;
            first_err_vec_q <= first_err_vec_d;
            first_err_ch_q  <= first_err_ch_d;
            err_q           <= err_d;
        end
    end

    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign pass          = (state_q == ST_DONE) && (error_count_q == 16'd0);
    assign err           = err_q;
    assign error_count   = error_count_q;
    assign vector_num    = vector_num_q;
    assign first_err_vec = first_err_vec_q;
    assign first_err_ch  = first_err_ch_q;

endmodule

// File: tb/tb_mips_trace_checker.sv
// tb/tb_mips_trace_checker.sv - scoreboard bench for mips_trace_checker (continue and stop-on-error builds)
module tb_mips_trace_checker;

    localparam int NCH = 6;
    localparam int CW  = 32;
    localparam int DEP = 8;
    localparam int AW  = 3;
    localparam int DW  = NCH * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [NCH-1:0] load_mask = '0;
    logic          load_last = 1'b0;
    logic          start = 1'b0;
    logic          sample = 1'b0;
    logic [DW-1:0] observed = '0;

    logic          busy_o [2];
    logic          done_o [2];
    logic          pass_o [2];
    logic          err_o  [2];
    logic [15:0]   ec_o   [2];
    logic [AW:0]   vn_o   [2];
    logic [AW-1:0] fev_o  [2];
    logic [NCH-1:0] fec_o [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_trace_checker #(.NUM_CH(NCH), .CH_W(CW), .DEPTH(DEP), .STOP_ON_ERR(0)) dut0 (
        .clk(clk), .reset(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_mask(load_mask), .load_last(load_last),
        .start(start), .sample(sample), .observed(observed),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err(err_o[0]),
        .error_count(ec_o[0]), .vector_num(vn_o[0]),
        .first_err_vec(fev_o[0]), .first_err_ch(fec_o[0])
    );

    mips_trace_checker #(.NUM_CH(NCH), .CH_W(CW), .DEPTH(DEP), .STOP_ON_ERR(1)) dut1 (
        .clk(clk), .reset(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_mask(load_mask), .load_last(load_last),
        .start(start), .sample(sample), .observed(observed),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err(err_o[1]),
        .error_count(ec_o[1]), .vector_num(vn_o[1]),
        .first_err_vec(fev_o[1]), .first_err_ch(fec_o[1])
    );

    // Reference model: 0 = idle, 1 = running, 2 = finished
    typedef struct {
        bit busy; bit done; bit pass; bit err;
        int ec; int vn; int fev; int fec;
    } exp_t;

    logic [DW-1:0]  m_data [2][DEP];
    logic [NCH-1:0] m_mask [2][DEP];
    bit             m_last [2][DEP];
    int             m_st [2];
    int             m_ptr [2];
    int             m_vn [2];
    int             m_ec [2];
    int             m_fev [2];
    int             m_fec [2];
    int             m_stop [2];

    exp_t q0 [$];
    exp_t q1 [$];
    logic smp_seen = 1'b0;

    task automatic chk(input int s, input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL dut%0d %s: actual=%0h required=%0h", s, nm, act, req);
        end
    endtask

    function automatic exp_t snap(input int s, input bit errv);
        exp_t e;
        e.busy = (m_st[s] == 1);
        e.done = (m_st[s] == 2);
        e.pass = (m_st[s] == 2) && (m_ec[s] == 0);
        e.err  = errv;
        e.ec   = m_ec[s];
        e.vn   = m_vn[s];
        e.fev  = m_fev[s];
        e.fec  = m_fec[s];
        return e;
    endfunction

    function automatic void model_reset(input int s);
        m_st[s] = 0; m_ptr[s] = 0; m_vn[s] = 0; m_ec[s] = 0; m_fev[s] = 0; m_fec[s] = 0;
    endfunction

    function automatic void model_start(input int s);
        if (m_st[s] != 1) begin
            m_st[s] = 1; m_ptr[s] = 0; m_vn[s] = 0; m_ec[s] = 0; m_fev[s] = 0; m_fec[s] = 0;
        end
    endfunction

    function automatic exp_t model_sample(input int s, input logic [DW-1:0] obs);
        bit errv = 0;
        int p;
        int mism = 0;
        if (m_st[s] == 1) begin
            p = m_ptr[s];
            for (int k = 0; k < NCH; k++) begin
                if (m_mask[s][p][k] && (obs[k*CW +: CW] != m_data[s][p][k*CW +: CW]))
                    mism += (1 << k);
            end
            if (mism != 0) begin
                errv = 1;
                if (m_ec[s] == 0) begin
                    m_fev[s] = p;
                    m_fec[s] = mism;
                end
                if (m_ec[s] < 65535) m_ec[s]++;
            end
            m_vn[s]++;
            if (m_last[s][p] || (p == DEP - 1) || ((m_stop[s] != 0) && (mism != 0)))
                m_st[s] = 2;
            m_ptr[s] = (p + 1) % DEP;
        end
        return snap(s, errv);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int a, input logic [DW-1:0] d, input logic [NCH-1:0] m,
                           input bit l, input bit st);
        load_en = 1'b1; load_addr = AW'(a); load_data = d; load_mask = m; load_last = l;
        start = st;
        for (int s = 0; s < 2; s++) begin
            if (m_st[s] == 0) begin
                m_data[s][a] = d; m_mask[s][a] = m; m_last[s][a] = l;
            end
            if (st) model_start(s);
        end
        cycle();
        load_en = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        for (int s = 0; s < 2; s++) model_start(s);
        cycle();
        start = 1'b0;
    endtask

    task automatic do_sample(input logic [DW-1:0] obs);
        sample = 1'b1; observed = obs;
        q0.push_back(model_sample(0, obs));
        q1.push_back(model_sample(1, obs));
        cycle();
        sample = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk(s, "rst_busy", 32'(busy_o[s]), 0);
            chk(s, "rst_done", 32'(done_o[s]), 0);
            chk(s, "rst_pass", 32'(pass_o[s]), 0);
            chk(s, "rst_err",  32'(err_o[s]),  0);
            chk(s, "rst_ec",   32'(ec_o[s]),   0);
            chk(s, "rst_vn",   32'(vn_o[s]),   0);
            chk(s, "rst_fev",  32'(fev_o[s]),  0);
            chk(s, "rst_fec",  32'(fec_o[s]),  0);
            model_reset(s);
        end
        cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] vec(input int v);
        logic [DW-1:0] d;
        for (int k = 0; k < NCH; k++) d[k*CW +: CW] = 32'((v + 1) * k);
        return d;
    endfunction

    function automatic logic [DW-1:0] vec_bad(input int v, input int k, input logic [31:0] val);
        logic [DW-1:0] d;
        d = vec(v);
        d[k*CW +: CW] = val;
        return d;
    endfunction

    task automatic load4();
        for (int v = 0; v < 4; v++) do_load(v, vec(v), 6'h3F, (v == 3), 1'b0);
    endtask

    always @(posedge clk) smp_seen <= sample;

    always @(negedge clk) begin
        exp_t e;
        int sz;
        for (int s = 0; s < 2; s++) begin
            if (smp_seen) begin
                sz = (s == 0) ? q0.size() : q1.size();
                chk(s, "sb_nonempty", 32'(sz != 0), 1);
                if (sz != 0) begin
                    e = (s == 0) ? q0.pop_front() : q1.pop_front();
                    chk(s, "busy", 32'(busy_o[s]), 32'(e.busy));
                    chk(s, "done", 32'(done_o[s]), 32'(e.done));
                    chk(s, "pass", 32'(pass_o[s]), 32'(e.pass));
                    chk(s, "err",  32'(err_o[s]),  32'(e.err));
                    chk(s, "error_count",   32'(ec_o[s]),  32'(e.ec));
                    chk(s, "vector_num",    32'(vn_o[s]),  32'(e.vn));
                    chk(s, "first_err_vec", 32'(fev_o[s]), 32'(e.fev));
                    chk(s, "first_err_ch",  32'(fec_o[s]), 32'(e.fec));
                end
            end else begin
                chk(s, "err_without_sample", 32'(err_o[s]), 0);
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] obs;
        logic [NCH-1:0] m;
        int lastpos, p, k, guard;

        m_stop[0] = 0;
        m_stop[1] = 1;
        model_reset(0);
        model_reset(1);

        // All-match run on a 4-entry table
        do_reset();
        load4();
        do_start();
        for (int v = 0; v < 4; v++) do_sample(vec(v));
        chk(0, "tp1_done", 32'(done_o[0]), 1);
        chk(0, "tp1_pass", 32'(pass_o[0]), 1);
        chk(0, "tp1_vn",   32'(vn_o[0]),   4);

        // Single bad channel on vector 1
        do_start();
        for (int v = 0; v < 4; v++)
            do_sample((v == 1) ? vec_bad(1, 2, 32'hDEADBEEF) : vec(v));
        chk(0, "tp2_ec",   32'(ec_o[0]),  1);
        chk(0, "tp2_fev",  32'(fev_o[0]), 1);
        chk(0, "tp2_fec",  32'(fec_o[0]), 32'h04);
        chk(0, "tp2_pass", 32'(pass_o[0]), 0);
        chk(1, "tp2_stop_vn", 32'(vn_o[1]), 2);

        // Mismatches on vectors 1 and 3
        do_start();
        for (int v = 0; v < 4; v++)
            do_sample((v == 1) ? vec_bad(1, 2, 32'hDEADBEEF) :
                      (v == 3) ? vec_bad(3, 0, 32'h12345678) : vec(v));
        chk(0, "tp3_ec",  32'(ec_o[0]),  2);
        chk(0, "tp3_fev", 32'(fev_o[0]), 1);
        chk(1, "tp3_stop_vn",   32'(vn_o[1]),   2);
        chk(1, "tp3_stop_done", 32'(done_o[1]), 1);

        // Load ignored in DONE, then masked-off channel after reset
        do_load(1, vec(1), 6'h00, 1'b0, 1'b0);
        do_reset();
        do_load(1, vec(1), 6'h3B, 1'b0, 1'b0);
        do_start();
        for (int v = 0; v < 4; v++)
            do_sample((v == 1) ? vec_bad(1, 2, 32'hDEADBEEF) : vec(v));
        chk(0, "tp4_pass", 32'(pass_o[0]), 1);
        chk(1, "tp4_pass", 32'(pass_o[1]), 1);

        // Reset mid-run, table retained
        do_reset();
        load4();
        do_start();
        do_sample(vec(0));
        do_sample(vec(1));
        do_reset();
        do_start();
        for (int v = 0; v < 4; v++) do_sample(vec(v));
        chk(0, "tp6_pass", 32'(pass_o[0]), 1);
        chk(0, "tp6_vn",   32'(vn_o[0]),   4);

        // No end marker: run ends at the table boundary
        do_reset();
        for (int v = 0; v < DEP; v++) do_load(v, vec(v), 6'h3F, 1'b0, 1'b0);
        do_start();
        for (int v = 0; v < DEP; v++) do_sample(vec(v));
        do_sample(vec(0));
        chk(0, "tp5_vn",   32'(vn_o[0]),   8);
        chk(0, "tp5_done", 32'(done_o[0]), 1);

        // Randomized runs
        for (int run = 0; run < 30; run++) do begin
            do_reset();
            lastpos = ($urandom_range(3) == 0) ? DEP : int'($urandom_range(DEP - 1));
            for (int a = 0; a < DEP; a++) begin
                for (int w = 0; w < NCH; w++) d[w*CW +: CW] = $urandom;
                case ($urandom_range(7))
                    0: m = '0;
                    1: m = NCH'($urandom);
                    default: m = '1;
                endcase
                do_load(a, d, m, (a == lastpos), (a == DEP - 1) && ($urandom_range(1) == 1));
            end
            if (m_st[0] != 1) do_start();
            guard = 0;
            while ((m_st[0] == 1 || m_st[1] == 1) && guard < 60) begin
                guard++;
                repeat ($urandom_range(2)) cycle();
                if ($urandom_range(9) == 0) do_start();
                if ($urandom_range(9) == 0)
                    do_load($urandom_range(DEP - 1), '0, '0, 1'b1, 1'b0);
                p = (m_st[0] == 1) ? m_ptr[0] : m_ptr[1];
                obs = m_data[0][p];
                if ($urandom_range(3) == 0) begin
                    k = $urandom_range(NCH - 1);
                    obs[k*CW +: CW] = obs[k*CW +: CW] ^ ($urandom | 32'h1);
                end
                do_sample(obs);
            end
            chk(0, "rand_terminated", 32'(guard < 60), 1);
            do_sample(m_data[0][0]);
        end while (0);

        repeat (3) cycle();
        chk(0, "sb_drained", 32'(q0.size()), 0);
        chk(1, "sb_drained", 32'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
